// File: rtl/alu_control_fsm.sv
// rtl/alu_control_fsm.sv - multi-cycle ALU/datapath control state machine
//
// Purpose: sequences FETCH/DECODE/execute/writeback for a small multi-cycle
// MIPS-style datapath, driving the ALU, memory, register-file and PC controls.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   opcode, funct             instruction fields, stable from DECODE to FETCH
//   mem_ready                 memory finishes the current mem_req access
//   isZero, overflow          ALU flags for the current operation
//   alu_op                    ALU operation (ADD/SUB/AND/OR/SLT encodings below)
//   alu_src_a, alu_src_b      ALU operand muxes
//   mem_req, mem_we, iord     memory request, write enable, address select
//   ir_write, pc_write, pc_src instruction-register load, PC load and source
//   reg_write, reg_dst, mem_to_reg  register-file write controls
//   exc                       one-cycle exception pulse
//   state                     current state encoding (debug)

module alu_control_fsm #(
   parameter bit TRAP_ON_OVF = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   input  logic       isZero,
   input  logic       overflow,
   output logic [2:0] alu_op,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       exc,
   output logic [3:0] state
);

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_R_WB     = 4'd3,
      S_EXEC_I   = 4'd4,
      S_I_WB     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_EXC      = 4'd12
   } state_t;

   state_t state_q, state_d;
   logic   is_addsub;
   logic   bad_funct;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      alu_op     = 3'b000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      exc        = 1'b0;
      is_addsub  = 1'b0;
      bad_funct  = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target PC+(imm<<2) is computed speculatively here.
            alu_src_b = 2'b11;
            alu_op    = ALU_ADD;
            case (opcode)
               6'h00:        state_d = S_EXEC_R;
               6'h23, 6'h2B: state_d = S_MEM_ADDR;
               6'h04, 6'h05: state_d = S_BRANCH;
               6'h08:        state_d = S_EXEC_I;
               6'h02:        state_d = S_JUMP;
               default:      state_d = S_EXC;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            case (funct)
               6'h20: begin alu_op = ALU_ADD; is_addsub = 1'b1; end
               6'h22: begin alu_op = ALU_SUB; is_addsub = 1'b1; end
               6'h24: alu_op = ALU_AND;
               6'h25: alu_op = ALU_OR;
               6'h2A: alu_op = ALU_SLT;
               default: begin alu_op = ALU_ADD; bad_funct = 1'b1; end
            endcase
            // Only signed arithmetic can trap; logic ops and SLT never do.
            if (bad_funct || (TRAP_ON_OVF && is_addsub && overflow))
               state_d = S_EXC;
            else
               state_d = S_R_WB;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
            state_d   = (TRAP_ON_OVF && overflow) ? S_EXC : S_I_WB;
         end
         S_I_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_ADDR: begin
            // Address arithmetic wraps; overflow is deliberately not a trap.
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
            state_d   = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'b01;
            pc_write  = ((opcode == 6'h04) && isZero) || ((opcode == 6'h05) && !isZero);
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
         end
         S_EXC: begin
            exc      = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'b11;
            state_d  = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Outputs are forced quiet for the whole reset window, not only after
      // the first reset edge, so a pending MEM_WR cannot keep mem_we high.
      if (rst) begin
         alu_op     = 3'b000;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         iord       = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = 2'b00;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         exc        = 1'b0;
      end
   end

   assign state = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_alu_control_fsm.sv
// tb/tb_alu_control_fsm.sv - self-checking bench for alu_control_fsm

module tb_alu_control_fsm;

   localparam logic [2:0] A_AND = 3'b000;
   localparam logic [2:0] A_OR  = 3'b001;
   localparam logic [2:0] A_ADD = 3'b010;
   localparam logic [2:0] A_SUB = 3'b110;
   localparam logic [2:0] A_SLT = 3'b111;

   typedef struct packed {
      logic [3:0] st;
      logic [2:0] alu_op;
      logic       src_a;
      logic [1:0] src_b;
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       exc;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       mem_ready = 1'b0;
   logic       isZero = 1'b0;
   logic       overflow = 1'b0;

   logic [2:0] alu_op0, alu_op1;
   logic       alu_src_a0, alu_src_a1;
   logic [1:0] alu_src_b0, alu_src_b1;
   logic       mem_req0, mem_we0, iord0, ir_write0, pc_write0;
   logic       mem_req1, mem_we1, iord1, ir_write1, pc_write1;
   logic [1:0] pc_src0, pc_src1;
   logic       reg_write0, reg_dst0, mem_to_reg0, exc0;
   logic       reg_write1, reg_dst1, mem_to_reg1, exc1;
   logic [3:0] state0, state1;

   alu_control_fsm #(.TRAP_ON_OVF(1'b1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .isZero(isZero), .overflow(overflow),
      .alu_op(alu_op0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
      .mem_req(mem_req0), .mem_we(mem_we0), .iord(iord0),
      .ir_write(ir_write0), .pc_write(pc_write0), .pc_src(pc_src0),
      .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
      .exc(exc0), .state(state0)
   );

   alu_control_fsm #(.TRAP_ON_OVF(1'b0)) dut_nt (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .isZero(isZero), .overflow(overflow),
      .alu_op(alu_op1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
      .mem_req(mem_req1), .mem_we(mem_we1), .iord(iord1),
      .ir_write(ir_write1), .pc_write(pc_write1), .pc_src(pc_src1),
      .reg_write(reg_write1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
      .exc(exc1), .state(state1)
   );

   obs_t obs0, obs1;
   assign obs0 = {state0, alu_op0, alu_src_a0, alu_src_b0, mem_req0, mem_we0, iord0,
                  ir_write0, pc_write0, pc_src0, reg_write0, reg_dst0, mem_to_reg0, exc0};
   assign obs1 = {state1, alu_op1, alu_src_a1, alu_src_b1, mem_req1, mem_we1, iord1,
                  ir_write1, pc_write1, pc_src1, reg_write1, reg_dst1, mem_to_reg1, exc1};

   always #5 clk = ~clk;

   int   chk_total = 0;
   int   chk_pass  = 0;
   obs_t exp0_q[$];
   obs_t exp1_q[$];
   string tag_q[$];

   // Expected-output model, one builder per state.
   function automatic obs_t e_rst();
      obs_t o = '0;
      return o;
   endfunction
   function automatic obs_t e_fetch(input logic rdy);
      obs_t o = '0;
      o.mem_req = 1'b1; o.src_b = 2'b01; o.alu_op = A_ADD;
      o.ir_write = rdy; o.pc_write = rdy;
      return o;
   endfunction
   function automatic obs_t e_decode();
      obs_t o = '0;
      o.st = 4'd1; o.src_b = 2'b11; o.alu_op = A_ADD;
      return o;
   endfunction
   function automatic obs_t e_exec_r(input logic [2:0] op);
      obs_t o = '0;
      o.st = 4'd2; o.src_a = 1'b1; o.alu_op = op;
      return o;
   endfunction
   function automatic obs_t e_r_wb();
      obs_t o = '0;
      o.st = 4'd3; o.reg_write = 1'b1; o.reg_dst = 1'b1;
      return o;
   endfunction
   function automatic obs_t e_exec_i();
      obs_t o = '0;
      o.st = 4'd4; o.src_a = 1'b1; o.src_b = 2'b10; o.alu_op = A_ADD;
      return o;
   endfunction
   function automatic obs_t e_i_wb();
      obs_t o = '0;
      o.st = 4'd5; o.reg_write = 1'b1;
      return o;
   endfunction
   function automatic obs_t e_mem_addr();
      obs_t o = '0;
      o.st = 4'd6; o.src_a = 1'b1; o.src_b = 2'b10; o.alu_op = A_ADD;
      return o;
   endfunction
   function automatic obs_t e_mem_rd();
      obs_t o = '0;
      o.st = 4'd7; o.mem_req = 1'b1; o.iord = 1'b1;
      return o;
   endfunction
   function automatic obs_t e_mem_wb();
      obs_t o = '0;
      o.st = 4'd8; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
      return o;
   endfunction
   function automatic obs_t e_mem_wr();
      obs_t o = '0;
      o.st = 4'd9; o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1;
      return o;
   endfunction
   function automatic obs_t e_branch(input logic pcw);
      obs_t o = '0;
      o.st = 4'd10; o.src_a = 1'b1; o.alu_op = A_SUB; o.pc_src = 2'b01; o.pc_write = pcw;
      return o;
   endfunction
   function automatic obs_t e_jump();
      obs_t o = '0;
      o.st = 4'd11; o.pc_write = 1'b1; o.pc_src = 2'b10;
      return o;
   endfunction
   function automatic obs_t e_exc();
      obs_t o = '0;
      o.st = 4'd12; o.exc = 1'b1; o.pc_write = 1'b1; o.pc_src = 2'b11;
      return o;
   endfunction

   // Drive one cycle of inputs, queue the expectation for each DUT, then
   // compare at the falling edge.
   task automatic cyc2(input logic r, input logic rdy, input logic z, input logic ov,
                       input obs_t e0, input obs_t e1, input string tag);
      obs_t  x0, x1;
      string t;
      rst = r; mem_ready = rdy; isZero = z; overflow = ov;
      exp0_q.push_back(e0);
      exp1_q.push_back(e1);
      tag_q.push_back(tag);
      @(negedge clk);
      x0 = exp0_q.pop_front();
      x1 = exp1_q.pop_front();
      t  = tag_q.pop_front();
      chk_total++;
      assert (obs0 === x0) chk_pass++;
      else $error("FAIL %s trap=1 observed=%h expected=%h", t, obs0, x0);
      chk_total++;
      assert (obs1 === x1) chk_pass++;
      else $error("FAIL %s trap=0 observed=%h expected=%h", t, obs1, x1);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic rdy, input logic z, input logic ov,
                      input obs_t e, input string tag);
      cyc2(1'b0, rdy, z, ov, e, e, tag);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset: outputs quiet even with memory ready and an LW opcode present.
      opcode = 6'h23;
      cyc2(1'b1, 1'b1, 1'b0, 1'b0, e_rst(), e_rst(), "reset0");
      cyc2(1'b1, 1'b1, 1'b0, 1'b0, e_rst(), e_rst(), "reset1");

      // R-type ADD
      opcode = 6'h00; funct = 6'h20;
      cyc(1, 0, 0, e_fetch(1), "add_fetch");
      cyc(1, 0, 0, e_decode(), "add_decode");
      cyc(1, 0, 0, e_exec_r(A_ADD), "add_exec");
      cyc(1, 0, 0, e_r_wb(), "add_wb");

      // R-type SUB, AND, OR, SLT (SLT with overflow set must not trap)
      funct = 6'h22;
      cyc(1, 0, 0, e_fetch(1), "sub_fetch");
      cyc(1, 0, 0, e_decode(), "sub_decode");
      cyc(1, 0, 0, e_exec_r(A_SUB), "sub_exec");
      cyc(1, 0, 0, e_r_wb(), "sub_wb");
      funct = 6'h24;
      cyc(1, 0, 0, e_fetch(1), "and_fetch");
      cyc(1, 0, 0, e_decode(), "and_decode");
      cyc(1, 0, 1, e_exec_r(A_AND), "and_exec_ovf");
      cyc(1, 0, 0, e_r_wb(), "and_wb");
      funct = 6'h25;
      cyc(1, 0, 0, e_fetch(1), "or_fetch");
      cyc(1, 0, 0, e_decode(), "or_decode");
      cyc(1, 0, 0, e_exec_r(A_OR), "or_exec");
      cyc(1, 0, 0, e_r_wb(), "or_wb");
      funct = 6'h2A;
      cyc(1, 0, 0, e_fetch(1), "slt_fetch");
      cyc(1, 0, 0, e_decode(), "slt_decode");
      cyc(1, 0, 1, e_exec_r(A_SLT), "slt_exec_ovf");
      cyc(1, 0, 0, e_r_wb(), "slt_wb");

      // R-type ADD with overflow: trap vs. writeback
      funct = 6'h20;
      cyc(1, 0, 0, e_fetch(1), "addovf_fetch");
      cyc(1, 0, 0, e_decode(), "addovf_decode");
      cyc(1, 0, 1, e_exec_r(A_ADD), "addovf_exec");
      cyc2(1'b0, 1, 0, 0, e_exc(), e_r_wb(), "addovf_next");

      // Unknown funct
      funct = 6'h00;
      cyc(1, 0, 0, e_fetch(1), "badf_fetch");
      cyc(1, 0, 0, e_decode(), "badf_decode");
      cyc(1, 0, 0, e_exec_r(A_ADD), "badf_exec");
      cyc(1, 0, 0, e_exc(), "badf_exc");

      // LW, two wait cycles in MEM_RD, overflow during address calc ignored
      opcode = 6'h23;
      cyc(1, 0, 0, e_fetch(1), "lw_fetch");
      cyc(1, 0, 0, e_decode(), "lw_decode");
      cyc(1, 0, 1, e_mem_addr(), "lw_addr_ovf");
      cyc(0, 0, 0, e_mem_rd(), "lw_rd_wait0");
      cyc(0, 0, 0, e_mem_rd(), "lw_rd_wait1");
      cyc(1, 0, 0, e_mem_rd(), "lw_rd_done");
      cyc(1, 0, 0, e_mem_wb(), "lw_wb");

      // SW with one wait cycle in FETCH
      opcode = 6'h2B;
      cyc(0, 0, 0, e_fetch(0), "sw_fetch_wait");
      cyc(1, 0, 0, e_fetch(1), "sw_fetch");
      cyc(1, 0, 0, e_decode(), "sw_decode");
      cyc(1, 0, 0, e_mem_addr(), "sw_addr");
      cyc(1, 0, 0, e_mem_wr(), "sw_wr");

      // Branches across both isZero values
      opcode = 6'h04;
      cyc(1, 1, 0, e_fetch(1), "beq_z_fetch");
      cyc(1, 1, 0, e_decode(), "beq_z_decode");
      cyc(1, 1, 0, e_branch(1), "beq_z_branch");
      cyc(1, 0, 0, e_fetch(1), "beq_nz_fetch");
      cyc(1, 0, 0, e_decode(), "beq_nz_decode");
      cyc(1, 0, 0, e_branch(0), "beq_nz_branch");
      opcode = 6'h05;
      cyc(1, 1, 0, e_fetch(1), "bne_z_fetch");
      cyc(1, 1, 0, e_decode(), "bne_z_decode");
      cyc(1, 1, 0, e_branch(0), "bne_z_branch");
      cyc(1, 0, 0, e_fetch(1), "bne_nz_fetch");
      cyc(1, 0, 0, e_decode(), "bne_nz_decode");
      cyc(1, 0, 0, e_branch(1), "bne_nz_branch");

      // Jump
      opcode = 6'h02;
      cyc(1, 0, 0, e_fetch(1), "j_fetch");
      cyc(1, 0, 0, e_decode(), "j_decode");
      cyc(1, 0, 0, e_jump(), "j_jump");

      // ADDI with and without overflow
      opcode = 6'h08;
      cyc(1, 0, 0, e_fetch(1), "addi_ovf_fetch");
      cyc(1, 0, 0, e_decode(), "addi_ovf_decode");
      cyc(1, 0, 1, e_exec_i(), "addi_ovf_exec");
      cyc2(1'b0, 1, 0, 0, e_exc(), e_i_wb(), "addi_ovf_next");
      cyc(1, 0, 0, e_fetch(1), "addi_fetch");
      cyc(1, 0, 0, e_decode(), "addi_decode");
      cyc(1, 0, 0, e_exec_i(), "addi_exec");
      cyc(1, 0, 0, e_i_wb(), "addi_wb");

      // Illegal opcode
      opcode = 6'h3F;
      cyc(1, 0, 0, e_fetch(1), "ill_fetch");
      cyc(1, 0, 0, e_decode(), "ill_decode");
      cyc(1, 0, 0, e_exc(), "ill_exc");

      // Reset while MEM_WR waits on memory
      opcode = 6'h2B;
      cyc(1, 0, 0, e_fetch(1), "swr_fetch");
      cyc(1, 0, 0, e_decode(), "swr_decode");
      cyc(1, 0, 0, e_mem_addr(), "swr_addr");
      cyc(0, 0, 0, e_mem_wr(), "swr_wr_wait");
      cyc2(1'b1, 0, 0, 0, e_rst(), e_rst(), "swr_in_reset");
      opcode = 6'h02;
      cyc(1, 0, 0, e_fetch(1), "swr_after_fetch");
      cyc(1, 0, 0, e_decode(), "swr_after_decode");
      cyc(1, 0, 0, e_jump(), "swr_after_jump");
      cyc(0, 0, 0, e_fetch(0), "final_fetch_wait");

      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule
